// File: rtl/srcz_interp_pkg.sv
// rtl/srcz_interp_pkg.sv - shared state encoding, constants and npix helper for srcz_interp
package srcz_interp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREP = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam int PIX_PER_PHRASE = 4;
  localparam int ZFRAC_BITS     = 16;

  // A phrase never consumes more than PIX_PER_PHRASE pixels; 0 and out-of-range codes mean a full phrase
  function automatic logic [2:0] npix_eff(input logic [2:0] n);
    if (n == 3'd0 || n > 3'(PIX_PER_PHRASE)) return 3'(PIX_PER_PHRASE);
    return n;
  endfunction

endpackage

// File: rtl/srcz_interp_lane.sv
// rtl/srcz_interp_lane.sv - one Z lane: accumulator plus pixel multiple, integer half out
module srcz_lane
  import srcz_interp_pkg::*;
(
  input  logic [31:0] acc,
  input  logic [31:0] mult,
  output logic [15:0] z_int
);

  // Wrapping 16.16 add; only the integer half is kept for the comparator
  always_comb begin
    z_int = 16'((acc + mult) >> ZFRAC_BITS);
  end

endmodule

// File: rtl/srcz_interp.sv
// rtl/srcz_interp.sv - source Z interpolator producing four 16-bit Z values per phrase
module srcz_interp
  import srcz_interp_pkg::*;
(
  input  logic        sys_clk,
  input  logic        xresetl,
  input  logic        zload,
  input  logic [31:0] zinit,
  input  logic [31:0] zinc,
  input  logic        step,
  input  logic [2:0]  npix,
  output logic        step_rdy,
  output logic [31:0] srczplo,
  output logic [31:0] srczphi,
  output logic        srcz_vld,
  input  logic        srcz_ack
);

  state_e      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] inc_q, inc_d;
  logic [31:0] m1_q, m1_d, m2_q, m2_d, m3_q, m3_d, m4_q, m4_d;
  logic [31:0] lo_q, lo_d, hi_q, hi_d;
  logic        vld_q, vld_d;

  logic [15:0] z0, z1, z2, z3;
  logic [31:0] madv;
  logic [31:0] acc_next;

  srcz_lane u_lane0 (.acc(acc_q), .mult(32'd0), .z_int(z0));
  srcz_lane u_lane1 (.acc(acc_q), .mult(m1_q),  .z_int(z1));
  srcz_lane u_lane2 (.acc(acc_q), .mult(m2_q),  .z_int(z2));
  srcz_lane u_lane3 (.acc(acc_q), .mult(m3_q),  .z_int(z3));

  // Single output register: a new phrase may enter whenever the held one is absent or being consumed
  assign step_rdy = (state_q == ST_RUN) && (!vld_q || srcz_ack);

  // Accumulator advance by the multiple matching the pixels this phrase consumed
  always_comb begin
    case (npix_eff(npix))
      3'd1:    madv = m1_q;
      3'd2:    madv = m2_q;
      3'd3:    madv = m3_q;
      default: madv = m4_q;
    endcase
    acc_next = acc_q + madv;
  end

  // Next-state: zload always restarts; PREP builds multiples; RUN emits phrases under ack handshake
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    inc_d   = inc_q;
    m1_d    = m1_q;
    m2_d    = m2_q;
    m3_d    = m3_q;
    m4_d    = m4_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    vld_d   = vld_q;
    if (zload) begin
      acc_d   = zinit;
      inc_d   = zinc;
      vld_d   = 1'b0;
      state_d = ST_PREP;
    end else begin
      case (state_q)
        ST_PREP: begin
          m1_d    = inc_q;
          m2_d    = inc_q << 1;
          m3_d    = inc_q + (inc_q << 1);
          m4_d    = inc_q << 2;
          state_d = ST_RUN;
        end
        ST_RUN: begin
          if (step && step_rdy) begin
            lo_d  = {z1, z0};
            hi_d  = {z3, z2};
            vld_d = 1'b1;
            acc_d = acc_next;
          end else if (srcz_ack && vld_q) begin
            vld_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // State and datapath registers with asynchronous clear
  always_ff @(posedge sys_clk or negedge xresetl) begin
    if (!xresetl) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      inc_q   <= '0;
      m1_q    <= '0;
      m2_q    <= '0;
      m3_q    <= '0;
      m4_q    <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      inc_q   <= inc_d;
      m1_q    <= m1_d;
      m2_q    <= m2_d;
      m3_q    <= m3_d;
      m4_q    <= m4_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      vld_q   <= vld_d;
    end
  end

  assign srczplo  = lo_q;
  assign srczphi  = hi_q;
  assign srcz_vld = vld_q;

endmodule

// File: tb/tb_srcz_interp.sv
// tb/tb_srcz_interp.sv - self-checking bench for srcz_interp
module tb_srcz_interp;

  logic        sys_clk = 1'b0;
  logic        xresetl;
  logic        zload;
  logic [31:0] zinit;
  logic [31:0] zinc;
  logic        step;
  logic [2:0]  npix;
  logic        step_rdy;
  logic [31:0] srczplo;
  logic [31:0] srczphi;
  logic        srcz_vld;
  logic        srcz_ack;

  srcz_interp dut (
    .sys_clk (sys_clk),
    .xresetl (xresetl),
    .zload   (zload),
    .zinit   (zinit),
    .zinc    (zinc),
    .step    (step),
    .npix    (npix),
    .step_rdy(step_rdy),
    .srczplo (srczplo),
    .srczphi (srczphi),
    .srcz_vld(srcz_vld),
    .srcz_ack(srcz_ack)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int passed = 0;

  // Reference model: Z of pixel k in the next phrase is start + k*increment
  logic [31:0] m_acc, m_inc, m_lo, m_hi;
  bit          m_vld, m_prep, m_run;
  logic        rdy_seen;

  function automatic logic [15:0] zpix(input logic [31:0] k);
    logic [31:0] t;
    t = m_acc + k * m_inc;
    return t[31:16];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_acc = '0; m_inc = '0; m_lo = '0; m_hi = '0;
    m_vld = 0; m_prep = 0; m_run = 0;
  endtask

  task automatic rst_pulse();
    @(negedge sys_clk);
    zload = 0; step = 0; srcz_ack = 0;
    xresetl = 0;
    #1;
    chk("rst_lo",  srczplo, 32'h0);
    chk("rst_hi",  srczphi, 32'h0);
    chk("rst_vld", {31'b0, srcz_vld}, 32'h0);
    chk("rst_rdy", {31'b0, step_rdy}, 32'h0);
    model_reset();
    @(negedge sys_clk);
    xresetl = 1;
  endtask

  task automatic cyc(input bit zl, input logic [31:0] zi, input logic [31:0] zc,
                     input bit st, input logic [2:0] np, input bit ak);
    bit   rdy;
    int   n;
    @(negedge sys_clk);
    zload = zl; zinit = zi; zinc = zc; step = st; npix = np; srcz_ack = ak;
    #1;
    rdy = m_run && (!m_vld || ak);
    rdy_seen = step_rdy;
    chk("step_rdy", {31'b0, step_rdy}, {31'b0, rdy});
    @(posedge sys_clk);
    n = (np >= 1 && np <= 4) ? int'(np) : 4;
    if (zl) begin
      m_acc = zi; m_inc = zc; m_vld = 0; m_prep = 1; m_run = 0;
    end else if (m_prep) begin
      m_prep = 0; m_run = 1;
    end else if (m_run) begin
      if (st && rdy) begin
        m_lo  = {zpix(1), zpix(0)};
        m_hi  = {zpix(3), zpix(2)};
        m_vld = 1;
        m_acc = m_acc + 32'(n) * m_inc;
      end else if (ak && m_vld) begin
        m_vld = 0;
      end
    end
    #1;
    chk("srczplo",  srczplo, m_lo);
    chk("srczphi",  srczphi, m_hi);
    chk("srcz_vld", {31'b0, srcz_vld}, {31'b0, m_vld});
  endtask

  logic [31:0] held;

  initial begin
    xresetl = 0; zload = 0; zinit = 0; zinc = 0; step = 0; npix = 0; srcz_ack = 0;
    model_reset();
    rst_pulse();

    // Basic phrase generation with half-pixel increment
    cyc(1, 32'h0010_0000, 32'h0000_8000, 0, 3'd4, 0);
    cyc(0, 32'h0, 32'h0, 1, 3'd4, 0);
    chk("prep_rdy", {31'b0, rdy_seen}, 32'h0);
    cyc(0, 32'hDEAD_BEEF, 32'h1234_5678, 1, 3'd4, 0);
    chk("basic_lo",  srczplo, 32'h0010_0010);
    chk("basic_hi",  srczphi, 32'h0011_0011);
    chk("basic_vld", {31'b0, srcz_vld}, 32'h1);
    cyc(0, 32'h0, 32'h0, 1, 3'd4, 1);
    chk("basic_lo2", srczplo, 32'h0012_0012);

    // Backpressure: step held, no ack
    held = srczplo;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 32'h0, 32'h0, 1, 3'd4, 0);
      chk("bp_rdy", {31'b0, rdy_seen}, 32'h0);
      chk("bp_hold", srczplo, held);
    end
    cyc(0, 32'h0, 32'h0, 1, 3'd4, 1);
    chk("bp_acc_rdy", {31'b0, rdy_seen}, 32'h1);
    chk("bp_new_lo", srczplo, 32'h0014_0014);

    // Wrap modulo 2^32
    cyc(1, 32'hFFFF_0000, 32'h0001_0000, 0, 3'd4, 1);
    cyc(0, 32'h0, 32'h0, 0, 3'd4, 0);
    cyc(0, 32'h0, 32'h0, 1, 3'd4, 0);
    chk("wrap_lo", srczplo, 32'h0000_FFFF);
    chk("wrap_hi", srczphi, 32'h0002_0001);

    // Partial phrase advance
    cyc(1, 32'h0, 32'h0001_0000, 0, 3'd4, 1);
    cyc(0, 32'h0, 32'h0, 0, 3'd4, 0);
    cyc(0, 32'h0, 32'h0, 1, 3'd2, 0);
    cyc(0, 32'h0, 32'h0, 1, 3'd4, 1);
    chk("part_lo", srczplo, 32'h0003_0002);

    // zload coincident with step while running
    cyc(1, 32'h0050_0000, 32'h0001_0000, 1, 3'd4, 1);
    chk("zl_vld", {31'b0, srcz_vld}, 32'h0);
    cyc(0, 32'h0, 32'h0, 1, 3'd4, 0);
    chk("zl_prep_rdy", {31'b0, rdy_seen}, 32'h0);
    chk("zl_prep_vld", {31'b0, srcz_vld}, 32'h0);
    cyc(0, 32'h0, 32'h0, 1, 3'd4, 0);
    chk("zl_first_lo", srczplo, 32'h0051_0050);

    // Reset mid-stream, then no phrase without zload
    rst_pulse();
    for (int i = 0; i < 3; i++) begin
      cyc(0, 32'h0, 32'h0, 1, 3'd4, 1);
      chk("post_rst_vld", {31'b0, srcz_vld}, 32'h0);
    end

    // Randomized traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) rst_pulse();
      else cyc($urandom_range(0, 29) == 0, $urandom, $urandom,
               $urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)),
               $urandom_range(0, 9) < 6);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/srcz_interp.md
SRCZ_INTERP -- requirements
Module: srcz_interp

Interface
REQ-001 SHALL have no parameters; pixels per phrase fixed at 4 (16-bit Z), Z accumulator width fixed at 32 (16.16).
REQ-002 SHALL have exactly one clock and one asynchronous active-low reset, as listed in REQ-003 and REQ-004.
REQ-003 sys_clk  in  1  system clock; all state on rising edge.
REQ-004 xresetl  in  1  asynchronous active-low reset.
REQ-005 zload  in  1  load pulse: latch zinit/zinc, restart interpolation.
REQ-006 zinit  in  32  starting Z, 16.16 fixed point.
REQ-007 zinc  in  32  per-pixel Z increment, 16.16, two's complement.
REQ-008 step  in  1  request next phrase of source Z.
REQ-009 npix  in  3  pixels consumed by this phrase, 1..4.
REQ-010 step_rdy  out  1  step accepted this cycle when step&step_rdy.
REQ-011 srczplo  out  32  {z1[31:16], z0[31:16]}, feeds Z comparator.
REQ-012 srczphi  out  32  {z3[31:16], z2[31:16]}, feeds Z comparator.
REQ-013 srcz_vld  out  1  srczplo/srczphi hold a valid phrase.
REQ-014 srcz_ack  in  1  comparator stage has consumed the current phrase.

Function
REQ-015 SHALL implement states IDLE, PREP, RUN; reset enters IDLE.
REQ-016 IDLE: step_rdy=0, srcz_vld=0; zload -> PREP.
REQ-017 PREP (exactly 1 cycle): SHALL register multiples m1=zinc, m2=zinc<<1, m3=zinc+(zinc<<1), m4=zinc<<2 (all mod 2^32); step_rdy=0; -> RUN.
REQ-018 zload in any state SHALL set acc=zinit, clear srcz_vld, and enter PREP; zload overrides a simultaneous step.
REQ-019 RUN: step_rdy = !srcz_vld | srcz_ack (single output register, bubble-free).
REQ-020 On accepted step SHALL register z0=acc, z1=acc+m1, z2=acc+m2, z3=acc+m3 into the outputs and set srcz_vld=1 on the next edge (latency 1 cycle).
REQ-021 Same accepted step SHALL advance acc by m[npix] (npix=1..4); npix 0 or 5..7 SHALL be treated as 4.
REQ-022 srcz_ack with no accepted step SHALL clear srcz_vld; outputs SHALL hold value while srcz_vld=1 and srcz_ack=0.
REQ-023 srcz_ack while srcz_vld=0 SHALL be ignored.
REQ-024 All additions SHALL wrap modulo 2^32 with no saturation or overflow flag; only bits [31:16] appear on outputs.
REQ-025 zinit/zinc changes without zload SHALL have no effect.

Reset
REQ-026 Reset SHALL force state=IDLE, acc=0, m1..m4=0, srczplo=0, srczphi=0, srcz_vld=0, step_rdy=0.
REQ-027 Reset asserted mid-operation SHALL discard pending phrase immediately; after release, no output until zload followed by PREP.

Structure
REQ-028 Shared package SHALL hold state encoding (IDLE=0, PREP=1, RUN=2), PIX_PER_PHRASE=4, ZFRAC_BITS=16.
REQ-029 One sub-module srcz_lane (32-bit acc + multiple adder, outputs integer half) SHALL be instantiated four times (z0..z3); the acc-advance adder is separate.

Verification
REQ-030 zload zinit=0x0010_0000, zinc=0x0000_8000; step npix=4 -> after 1 cycle srczplo=0x0010_0010, srczphi=0x0011_0011, vld=1; next step gives srczplo=0x0012_0012.
REQ-031 Wrap: zinit=0xFFFF_0000, zinc=0x0001_0000, step -> srczplo=0x0000_FFFF, srczphi=0x0002_0001.
REQ-032 Partial phrase: zinit=0, zinc=0x0001_0000, step npix=2 then step npix=4 -> second phrase srczplo=0x0003_0002.
REQ-033 Backpressure: srcz_ack held 0 for 3 cycles with step high -> step_rdy=0, outputs stable; ack=1 -> step accepted same cycle, new phrase next cycle.
REQ-034 zload coincident with step in RUN -> vld=0, step_rdy=0 for PREP cycle, first phrase from new zinit; reset pulse mid-stream -> all outputs 0, no phrase until new zload.
